// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // 0 = core load/store unit, 1 = DMA/debug loader
  typedef logic port_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin winner selection
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  port_id_t   last_grant,
  output logic       any_valid,
  output port_id_t   winner
);

  // a lone requester wins; on a tie the port not served last wins
  always_comb begin
    any_valid = |req_valid;
    if (&req_valid) winner = ~last_grant;
    else            winner = req_valid[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and one-cycle access sequencer for data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   mem_write_enable,
  output logic                   mem_read_enable,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_writedata,
  input  logic [DATA_W-1:0]      mem_readdata
);

  arb_state_t state;
  port_id_t   last_grant;
  port_id_t   lat_port;
  port_id_t   winner;
  logic       lat_we;
  logic       lat_err;
  logic       any_valid;
  logic       can_accept;
  logic       handshake;
  logic       win_err;

  rr_arb2 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  // ready goes only to the winner, never while an access is in flight or reset is held
  always_comb begin
    can_accept = rst_n && (state != ACCESS);
    handshake  = can_accept && any_valid;
    req_ready  = '0;
    if (handshake) req_ready[winner] = 1'b1;
    win_err    = (req_addr[winner] >= ADDR_W'(MEM_WORDS));
  end

  // latch on handshake, drive memory for exactly one cycle, then pulse the completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      lat_port         <= 1'b0;
      lat_we           <= 1'b0;
      lat_err          <= 1'b0;
      resp_valid       <= '0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= '0;
      mem_writedata    <= '0;
    end else begin
      case (state)
        ACCESS: begin
          state            <= RESP;
          resp_valid       <= {lat_port, ~lat_port};
          resp_rdata       <= (!lat_we && !lat_err) ? mem_readdata : '0;
          resp_err         <= lat_err;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          mem_address      <= '0;
          mem_writedata    <= '0;
        end
        default: begin
          resp_valid <= '0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          if (handshake) begin
            state            <= ACCESS;
            last_grant       <= winner;
            lat_port         <= winner;
            lat_we           <= req_we[winner];
            lat_err          <= win_err;
            mem_write_enable <= req_we[winner] && !win_err;
            mem_read_enable  <= !req_we[winner] && !win_err;
            mem_address      <= req_addr[winner];
            mem_writedata    <= req_wdata[winner];
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 1024;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_we = '0;
  logic [1:0][AW-1:0]  req_addr = '0;
  logic [1:0][DW-1:0]  req_wdata = '0;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [DW-1:0]       resp_rdata;
  logic                resp_err;
  logic                mem_write_enable;
  logic                mem_read_enable;
  logic [AW-1:0]       mem_address;
  logic [DW-1:0]       mem_writedata;
  logic [DW-1:0]       mem_readdata;

  logic [DW-1:0] ram     [MW];
  logic [DW-1:0] ref_mem [MW];

  int n_checks = 0;
  int n_pass   = 0;
  int obs0 = 0;
  int obs1 = 0;

  typedef struct packed {
    logic          active;
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          acc;
  logic          rsp_active;
  logic          rsp_port;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic          last_g;
  logic [1:0]    hs;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  // data memory: falling-edge write, combinational read
  always @(negedge clk)
    if (mem_write_enable && mem_address < MW) ram[mem_address[9:0]] <= mem_writedata;
  assign mem_readdata = (mem_address < MW) ? ram[mem_address[9:0]] : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    acc        = '0;
    rsp_active = 1'b0;
    rsp_port   = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    last_g     = 1'b1;
    hs         = '0;
  endtask

  // one clock: compare this cycle against the reference, then advance the reference
  task automatic step();
    logic [1:0] exp_ready;
    logic       w;
    logic       aerr;
    @(negedge clk);
    exp_ready = '0;
    w = 1'b0;
    if (!acc.active && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? ~last_g : req_valid[1];
      exp_ready[w] = 1'b1;
    end
    chk("req_ready", req_ready, exp_ready);
    aerr = acc.addr >= MW;
    chk("mem_en", {mem_write_enable, mem_read_enable},
        (acc.active && !aerr) ? {acc.we, !acc.we} : 2'b00);
    chk("mem_addr", mem_address, acc.active ? acc.addr : '0);
    chk("mem_wdata", mem_writedata, acc.active ? acc.wdata : '0);
    chk("resp_valid", resp_valid, rsp_active ? (rsp_port ? 2'b10 : 2'b01) : 2'b00);
    if (rsp_active) begin
      chk("resp_rdata", resp_rdata, rsp_data);
      chk("resp_err", resp_err, rsp_err);
    end
    obs0 += int'(req_ready[0] && req_valid[0]);
    obs1 += int'(req_ready[1] && req_valid[1]);

    rsp_active = acc.active;
    if (acc.active) begin
      rsp_port = acc.port;
      rsp_err  = aerr;
      rsp_data = (!acc.we && !aerr) ? ref_mem[acc.addr[9:0]] : '0;
      if (acc.we && !aerr) ref_mem[acc.addr[9:0]] = acc.wdata;
    end
    hs  = exp_ready;
    acc = '0;
    if (exp_ready != 2'b00) begin
      acc    = '{1'b1, w, req_we[w], req_addr[w], req_wdata[w]};
      last_g = w;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return AW'(MW - 1);
      1:       return AW'(MW);
      2:       return $urandom;
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic new_req(input int p);
    req_valid[p] = 1'b1;
    req_we[p]    = 1'($urandom_range(0, 1));
    req_addr[p]  = pick_addr();
    req_wdata[p] = $urandom;
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic got;
    got = 1'b0;
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = hs[p];
    end
    req_valid[p] = 1'b0;
    chk("issue_hs", got, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int mism;
    int o1;
    for (int i = 0; i < MW; i++) begin
      ram[i]     = DW'(i) * 32'h9E37_79B9;
      ref_mem[i] = DW'(i) * 32'h9E37_79B9;
    end
    ram[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    model_reset();

    // reset state, with both ports requesting
    req_valid = 2'b11;
    #12;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_outs", {resp_valid, resp_err, mem_write_enable, mem_read_enable}, '0);
    chk("rst_bus", {mem_address, mem_writedata, resp_rdata}, '0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single read, then write followed back-to-back by read
    issue(0, 1'b0, 5, 0);
    idle(3);
    issue(1, 1'b1, 7, 32'h1234);
    issue(1, 1'b0, 7, 0);
    idle(3);

    // out of range read and write, and the last legal word
    issue(0, 1'b0, AW'(MW), 0);
    idle(2);
    issue(1, 1'b1, AW'(MW), 32'hBAD0_BAD0);
    issue(0, 1'b1, AW'(MW - 1), 32'h5A5A_0001);
    issue(0, 1'b0, AW'(MW - 1), 0);
    idle(3);

    // withdrawn request: port 1 appears during port 0's access and leaves
    o1 = obs1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 3;
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 4; req_wdata[1] = 32'h4444;
    step();
    req_valid[1] = 1'b0;
    idle(3);
    chk("withdraw_no_grant", obs1 - o1, 0);

    // reset in the middle of a read access
    issue(0, 1'b0, 9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", {mem_write_enable, mem_read_enable}, 2'b00);
    chk("midrst_bus", {mem_address, mem_writedata}, '0);
    chk("midrst_resp", {resp_valid, resp_err, resp_rdata}, '0);
    model_reset();
    @(negedge clk);
    chk("midrst_resp_n", resp_valid, 2'b00);
    @(posedge clk);
    #1;
    chk("midrst_resp_p", resp_valid, 2'b00);

    // contention from reset: both ports continuously valid
    new_req(0);
    new_req(1);
    rst_n = 1'b1;
    obs0 = 0;
    obs1 = 0;
    step();
    chk("first_tie_port0", hs, 2'b01);
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < 2; p++) if (hs[p]) new_req(p);
      step();
    end
    chk("starve0", obs0 >= 4, 1'b1);
    chk("starve1", obs1 >= 4, 1'b1);
    chk("fair", (obs0 - obs1 <= 1) && (obs1 - obs0 <= 1), 1'b1);

    // random traffic with withdrawals
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (hs[p] || !req_valid[p]) begin
          if ($urandom_range(0, 2) != 0) new_req(p);
          else req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[p] = 1'b0;
        end
      end
      step();
    end
    req_valid = 2'b00;
    idle(4);

    mism = 0;
    for (int i = 0; i < MW; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-cycle core's word-addressed data memory. Port 0 is the core load/store unit and port 1 is the DMA/debug loader. It grants one requester at a time with round-robin fairness, drives the memory's enable, address and write-data inputs for exactly one access cycle, and returns read data or a completion with an out-of-range error flag. It sits between the requesters and the data memory, whose write commits on the falling clock edge and whose read path is combinational.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 32, address width (word address)
- `MEM_WORDS`, 1024, number of implemented words; valid addresses are 0..MEM_WORDS-1
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid[1:0]`  in  2  request pending, per port
- `req_we[1:0]`  in  2  1 = write, 0 = read
- `req_addr[0..1]`  in  2×ADDR_W  word address
- `req_wdata[0..1]`  in  2×DATA_W  write data
- `req_ready[1:0]`  out  2  request accepted this cycle when valid && ready
- `resp_valid[1:0]`  out  2  one-cycle completion pulse
- `resp_rdata`  out  DATA_W  read data, shared by both ports, qualified by resp_valid
- `resp_err`  out  1  address out of range, qualified by resp_valid
- `mem_write_enable`  out  1  to memory
- `mem_read_enable`  out  1  to memory
- `mem_address`  out  ADDR_W  to memory
- `mem_writedata`  out  DATA_W  to memory
- `mem_readdata`  in  DATA_W  from memory (combinational)

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: exactly one cycle, memory driven.
  - RESP: exactly one cycle, completion pulse.
- Transitions:
  - IDLE → ACCESS on a handshake.
  - ACCESS → RESP unconditionally.
  - RESP → ACCESS on a new handshake, else RESP → IDLE.
- req_ready is asserted only in IDLE or RESP, and only for the arbitration winner. The other port's ready stays 0.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- On handshake, latch into registers: port id, we, addr, wdata, and range check result (err = addr ≥ MEM_WORDS).
- ACCESS outputs:
  - mem_address = latched addr; mem_writedata = latched wdata.
  - mem_write_enable = we && !err; mem_read_enable = !we && !err.
- Erroneous accesses never assert either memory enable.
- At the end of ACCESS, register resp_rdata:
  - mem_readdata for a valid read.
  - 0 for a write or an error.
- Register resp_err with the latched err.
- RESP: resp_valid[port] = 1; the other bit is 0.
- Outside ACCESS, mem_write_enable, mem_read_enable, mem_address and mem_writedata are all 0.
- Requesters hold valid and payload stable until handshake. Dropping valid before handshake is legal and simply withdraws the request.

## Timing
- Handshake at rising edge k. ACCESS spans cycle k..k+1. resp_valid is high for cycle k+1..k+2. Latency is 2 cycles.
- The memory write commits at the falling edge inside ACCESS.
- Back-to-back throughput is one access per 2 cycles, because RESP accepts the next request.
- Reset values:
  - State IDLE, last_grant = 1.
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_err, and all mem_* outputs.
- Reset asserted mid-ACCESS:
  - Memory enables drop immediately (asynchronously).
  - The access is abandoned and no response is issued.
  - A write may or may not have committed, depending on whether the falling edge was reached.
- Simultaneous valid on both ports in RESP: arbitrate against the just-completed port.
- Address exactly MEM_WORDS → err. Address MEM_WORDS-1 → legal access.

## Structure
- Package `dmem_arb_pkg` holds:
  - State enum `arb_state_t` {IDLE, ACCESS, RESP}.
  - Port-id typedef.
  - Default width constants.
- Optional sub-module `rr_arb2`: combinational 2-way round-robin winner from `req_valid` and `last_grant`. Everything else lives in `dmem_arbiter`.

## Test plan
- Single read, no contention:
  - Preload memory word 5 = 0xDEADBEEF.
  - Port 0 reads addr 5 → ready at edge 0, resp_valid[0] two cycles later, resp_rdata = 0xDEADBEEF, err = 0.
- Write then read:
  - Port 1 writes 0x1234 to addr 7, then reads addr 7.
  - Second response returns 0x1234.
  - mem_write_enable is high for exactly one cycle.
- Contention:
  - Both ports valid continuously from reset.
  - Grants alternate 0, 1, 0, 1; each handshake is 2 cycles apart.
  - No port is starved.
- Out of range:
  - Read addr 1024 → resp_err = 1, resp_rdata = 0, no memory enable ever asserted.
  - Write to addr 1024 → memory contents unchanged.
- Reset mid-operation:
  - Assert rst_n low during ACCESS of a read.
  - All outputs go to 0 immediately and no resp_valid appears.
  - After release, port 0 wins the first tie.
- Withdrawn request:
  - Port 1 raises valid while port 0 is granted, then drops it before its ready.
  - No grant and no response for port 1.
